// File: rtl/upsampler_stream.sv
// upsampler_stream: streaming integer upsampler with valid/ready on both sides.
// Each accepted sample produces R output beats. Beat 0 carries the sample and
// beats 1..R-1 carry zero (mode 0) or the held sample (mode 1). The ratio and
// mode are captured at acceptance, so changes mid-group have no effect.
// Optional feature macro: UPSAMPLER_GAIN_COMP_EN. When defined, zero-stuff
// beat 0 carries s_data * R, saturated to the signed DATA_W range.
module upsampler_stream #(
    parameter int DATA_W    = 8,
    parameter int MAX_RATIO = 16,
    parameter int RW        = $clog2(MAX_RATIO + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RW-1:0]     ratio,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       phase_q, phase_d;
    logic [RW-1:0]       ratio_q, ratio_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_first_q, m_first_d;

    logic [RW-1:0]       eff_ratio;
    logic [DATA_W-1:0]   beat0_data;
    logic                last_beat;
    logic                in_xfer;
    logic                out_xfer;

    // Effective ratio: 0 behaves as 1, anything above MAX_RATIO is clamped.
    always_comb begin
        if (ratio == '0) begin
            eff_ratio = RW'(1);
        end else if (ratio > RW'(MAX_RATIO)) begin
            eff_ratio = RW'(MAX_RATIO);
        end else begin
            eff_ratio = ratio;
        end
    end

`ifdef UPSAMPLER_GAIN_COMP_EN
    localparam int PW = DATA_W + RW + 1;
    localparam logic signed [PW-1:0] SAT_MAX = $signed({{(RW + 2){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [PW-1:0] SAT_MIN = $signed({{(RW + 2){1'b1}}, {(DATA_W - 1){1'b0}}});

    logic signed [PW-1:0] gain_prod;

    // Zero-stuff beat 0 is scaled by R to restore passband gain; hold mode passes through.
    always_comb begin
        gain_prod = $signed(s_data) * $signed({1'b0, eff_ratio});
        if (mode) begin
            beat0_data = s_data;
        end else if (gain_prod > SAT_MAX) begin
            beat0_data = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (gain_prod < SAT_MIN) begin
            beat0_data = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            beat0_data = gain_prod[DATA_W-1:0];
        end
    end
`else
    // Beat 0 carries the accepted sample unmodified.
    always_comb begin
        beat0_data = s_data;
    end
`endif

    assign last_beat = (phase_q == (ratio_q - RW'(1)));
    assign m_valid   = (state_q == EMIT);
    // Ready depends only on state, phase, m_ready and reset; never on s_valid.
    assign s_ready   = !reset && ((state_q == IDLE) || (last_beat && m_ready));
    assign in_xfer   = s_valid && s_ready;
    assign out_xfer  = m_valid && m_ready;
    assign m_data    = m_data_q;
    assign m_first   = m_first_q;

    // Next-state logic: load on acceptance, otherwise advance or retire the group.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        ratio_d   = ratio_q;
        mode_d    = mode_q;
        sample_d  = sample_q;
        m_data_d  = m_data_q;
        m_first_d = m_first_q;

        if (in_xfer) begin
            // Acceptance happens from IDLE or on the last beat; both reload a group.
            state_d   = EMIT;
            phase_d   = '0;
            ratio_d   = eff_ratio;
            mode_d    = mode;
            sample_d  = s_data;
            m_data_d  = beat0_data;
            m_first_d = 1'b1;
        end else if (out_xfer) begin
            if (last_beat) begin
                state_d   = IDLE;
                m_first_d = 1'b0;
            end else begin
                phase_d   = phase_q + RW'(1);
                m_first_d = 1'b0;
                m_data_d  = mode_q ? sample_q : '0;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            ratio_q   <= RW'(1);
            mode_q    <= 1'b0;
            sample_q  <= '0;
            m_data_q  <= '0;
            m_first_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ratio_q   <= ratio_d;
            mode_q    <= mode_d;
            sample_q  <= sample_d;
            m_data_q  <= m_data_d;
            m_first_q <= m_first_d;
        end
    end

endmodule

// File: tb/tb_upsampler_stream.sv
// Self-checking bench for upsampler_stream. A queue-based model expands each
// observed input transfer into its R expected beats; a negedge monitor compares
// every output cycle against it. Directed tests add literal expectations.
module tb_upsampler_stream;

    localparam int DATA_W    = 8;
    localparam int MAX_RATIO = 16;
    localparam int RW        = $clog2(MAX_RATIO + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [RW-1:0]     ratio = '0;
    logic              mode = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_first;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              f;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] log_d[$];
    logic              log_f[$];

    int tests = 0;
    int fails = 0;
    int stalls = 0;
    int mr_pat = 0;
    int mr_cnt = 0;

    upsampler_stream #(.DATA_W(DATA_W), .MAX_RATIO(MAX_RATIO)) dut (
        .clock  (clock),
        .reset  (reset),
        .ratio  (ratio),
        .mode   (mode),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_first(m_first)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the beats one accepted sample must produce, straight from the rules.
    task automatic model_push(input logic [DATA_W-1:0] d, input int r_raw, input logic md);
        int r;
        int v;
        beat_t b;
        r = (r_raw == 0) ? 1 : ((r_raw > MAX_RATIO) ? MAX_RATIO : r_raw);
        v = int'($signed(d));
`ifdef UPSAMPLER_GAIN_COMP_EN
        if (!md) begin
            v = v * r;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
        end
`endif
        for (int k = 0; k < r; k++) begin
            b.d = (k == 0) ? DATA_W'(v) : (md ? d : '0);
            b.f = (k == 0);
            exp_q.push_back(b);
        end
    endtask

    // m_ready pattern: 0 = always ready, 1 = repeating 1,0,0.
    always @(posedge clock) begin
        #1;
        if (mr_pat == 0) begin
            m_ready = 1'b1;
        end else begin
            m_ready = (mr_cnt % 3 == 0);
            mr_cnt++;
        end
    end

    // Monitor: compare outputs to model on every cycle, then record transfers.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("m_valid_vs_model", {31'b0, m_valid}, {31'b0, exp_q.size() != 0});
            if (m_valid && exp_q.size() != 0) begin
                check("m_data_vs_model", {24'b0, m_data}, {24'b0, exp_q[0].d});
                check("m_first_vs_model", {31'b0, m_first}, {31'b0, exp_q[0].f});
                if (m_ready) begin
                    log_d.push_back(m_data);
                    log_f.push_back(m_first);
                    void'(exp_q.pop_front());
                end
            end
            if (s_valid && s_ready) model_push(s_data, int'(ratio), mode);
        end
    end

    // Present one sample and wait (bounded) until it is accepted.
    task automatic send(input logic [DATA_W-1:0] d, input int r, input logic md);
        logic acc;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        ratio   = RW'(r);
        mode    = md;
        n = 0;
        do begin
            @(negedge clock);
            acc = s_ready;
            if (!acc) stalls++;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(exp_q.size() == 0 && !m_valid) && n < 300);
        if (n >= 300) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_f.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DATA_W-1:0] g0, g1, g2;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_data", {24'b0, m_data}, 32'd0);
        check("rst_m_first", {31'b0, m_first}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_s_ready", {31'b0, s_ready}, 32'd1);

        // 1: ratio 4 zero-stuff, back-to-back with no bubble
        clear_log();
        stalls = 0;
        send(8'h05, 4, 1'b0);
        send(8'h7F, 4, 1'b0);
        check("t1_stalls", stalls, 32'd3);
        drain();
        check("t1_count", log_d.size(), 32'd8);
        check("t1_b0", {24'b0, log_d[0]}, 32'h05);
        check("t1_b1", {24'b0, log_d[1]}, 32'h00);
        check("t1_b3", {24'b0, log_d[3]}, 32'h00);
        check("t1_b4", {24'b0, log_d[4]}, 32'h7F);
        check("t1_b7", {24'b0, log_d[7]}, 32'h00);
        check("t1_f0", {31'b0, log_f[0]}, 32'd1);
        check("t1_f1", {31'b0, log_f[1]}, 32'd0);
        check("t1_f4", {31'b0, log_f[4]}, 32'd1);

        // 2: ratio 3 hold; s_ready low on beats 0 and 1
        clear_log();
        send(8'hA3, 3, 1'b1);
        @(negedge clock);
        check("t2_ready_b0", {31'b0, s_ready}, 32'd0);
        check("t2_data_b0", {24'b0, m_data}, 32'hA3);
        @(negedge clock);
        check("t2_ready_b1", {31'b0, s_ready}, 32'd0);
        @(negedge clock);
        check("t2_ready_b2", {31'b0, s_ready}, 32'd1);
        @(posedge clock);
        #1;
        drain();
        check("t2_count", log_d.size(), 32'd3);
        check("t2_b2", {24'b0, log_d[2]}, 32'hA3);
        check("t2_valid_off", {31'b0, m_valid}, 32'd0);

        // 3: ratio 4 with m_ready toggling 1,0,0
        clear_log();
        mr_cnt = 0;
        mr_pat = 1;
        send(8'h11, 4, 1'b0);
        send(8'h22, 4, 1'b0);
        drain();
        mr_pat = 0;
        check("t3_count", log_d.size(), 32'd8);
        check("t3_b0", {24'b0, log_d[0]}, 32'h11);
        check("t3_b4", {24'b0, log_d[4]}, 32'h22);
        check("t3_f5", {31'b0, log_f[5]}, 32'd0);

        // 4: ratio 0 and 1 stream one sample per cycle; ratio 31 clamps to 16
        for (int r = 0; r < 2; r++) begin
            clear_log();
            stalls = 0;
            for (int i = 1; i <= 8; i++) send(DATA_W'(i), r, 1'b0);
            check("t4_stalls", stalls, 32'd0);
            drain();
            check("t4_count", log_d.size(), 32'd8);
            for (int i = 0; i < 8; i++) begin
                if (i < log_d.size()) begin
                    check("t4_data", {24'b0, log_d[i]}, i + 1);
                    check("t4_first", {31'b0, log_f[i]}, 32'd1);
                end
            end
        end
        clear_log();
        send(8'h09, 31, 1'b1);
        drain();
        check("t4_clamp_count", log_d.size(), 32'd16);

        // 5: reset at beat 2 of a ratio 8 group
        clear_log();
        send(8'h5A, 8, 1'b1);
        n = 0;
        while (log_d.size() < 2 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("t5_reached_b2", log_d.size(), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        check("t5_ready_in_rst", {31'b0, s_ready}, 32'd0);
        @(posedge clock);
        #1;
        check("t5_m_valid", {31'b0, m_valid}, 32'd0);
        check("t5_m_data", {24'b0, m_data}, 32'd0);
        check("t5_m_first", {31'b0, m_first}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("t5_ready_after", {31'b0, s_ready}, 32'd1);
        @(posedge clock);
        #1;

        // 6: beat 0 gain (scaled and saturated only with gain compensation)
        clear_log();
        send(8'h10, 4, 1'b0);
        send(8'h30, 4, 1'b0);
        send(8'hD0, 4, 1'b0);
        drain();
`ifdef UPSAMPLER_GAIN_COMP_EN
        g0 = 8'h40; g1 = 8'h7F; g2 = 8'h80;
`else
        g0 = 8'h10; g1 = 8'h30; g2 = 8'hD0;
`endif
        check("t6_count", log_d.size(), 32'd12);
        check("t6_b0", {24'b0, log_d[0]}, {24'b0, g0});
        check("t6_b4", {24'b0, log_d[4]}, {24'b0, g1});
        check("t6_b8", {24'b0, log_d[8]}, {24'b0, g2});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
